// File: rtl/eig_if.sv
// Request/result bundle for eig_engine: coefficient request in, eigen-parameter result out.
// engine uses the eng modport, the requester/consumer uses the host modport.
interface eig_if #(
    parameter int W   = 32,
    parameter int CHW = 2
);
    logic           ena;
    logic           in_valid;
    logic           in_ready;
    logic [CHW-1:0] in_ch;
    logic [W-1:0]   a0;
    logic [W-1:0]   a1;
    logic           out_valid;
    logic           out_ready;
    logic [CHW-1:0] out_ch;
    logic [2:0]     regime;
    logic [W-1:0]   kappa;
    logic [W-1:0]   inv_kappa;
    logic [W-1:0]   neg_beta_half;
    logic           invalid;
    logic           regime_chg;
    logic           busy;

    modport host (
        output ena, in_valid, in_ch, a0, a1, out_ready,
        input  in_ready, out_valid, out_ch, regime, kappa, inv_kappa,
               neg_beta_half, invalid, regime_chg, busy
    );

    modport eng (
        input  ena, in_valid, in_ch, a0, a1, out_ready,
        output in_ready, out_valid, out_ch, regime, kappa, inv_kappa,
               neg_beta_half, invalid, regime_chg, busy
    );
endinterface

// File: rtl/eig_engine.sv
// Damped-oscillator eigen parameters: regime, kappa = sqrt(|a1^2-4a0|)/2, 1/kappa, -a1/2.
// Latency W+2F+3 enabled cycles from accept to out_valid; one request in flight.
// Result holds in OUT until out_ready; ena low freezes everything and blocks both handshakes.
module eig_engine #(
    parameter int W   = 32,
    parameter int F   = 16,
    parameter int NCH = 4,
    parameter int CHW = $clog2(NCH)
) (
    input  logic clk,
    input  logic rst,
    eig_if.eng   bus
);
    localparam int D   = 2*W + 3;
    localparam int QW  = 2*F + 1;
    localparam int CW  = $clog2(W + 2*F + 2);
    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, DISC, SQRT, RECIP, OUT} state_t;
    state_t state, state_n;

    logic [CW-1:0]   cnt;
    logic [CHW-1:0]  ch_r;
    logic [W-1:0]    a0_r, a1_r;
    logic [2*W-1:0]  rad;
    logic [W+1:0]    rem_s;
    logic [W-1:0]    root;
    logic [W-1:0]    rem_d;
    logic [QW-1:0]   quo;
    logic [W-1:0]    kappa_r, inv_r, nbh_r;
    logic [2:0]      regime_r;
    logic            invalid_r, chg_r;
    logic [2:0]      tbl [NCH];

    logic accept, deliver;
    assign bus.in_ready = (state == IDLE) && bus.ena && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    assign deliver      = (state == OUT) && bus.out_ready && bus.ena;

    // Discriminant at 2F fraction bits; a0 << (F+2) is 4*a0 rescaled.
    logic signed [D-1:0] a1x, a0x, disc;
    logic [D-1:0]        dabs;
    logic [2*W-1:0]      rad_in;
    assign a1x    = D'($signed(a1_r));
    assign a0x    = D'($signed(a0_r));
    assign disc   = a1x * a1x - (a0x <<< (F + 2));
    assign dabs   = disc[D-1] ? $unsigned(-disc) : $unsigned(disc);
    assign rad_in = (|dabs[D-1:2*W]) ? {(2*W){1'b1}} : dabs[2*W-1:0];

    // Restoring square root, two radicand bits per step.
    logic [W+3:0] sq_cat, sq_trial;
    logic         sq_ge;
    logic [W+1:0] sq_rem_n;
    logic [W-1:0] sq_root_n;
    assign sq_cat    = {rem_s, rad[2*W-1 -: 2]};
    assign sq_trial  = {2'b00, root, 2'b01};
    assign sq_ge     = sq_cat >= sq_trial;
    assign sq_rem_n  = sq_ge ? (W+2)'(sq_cat - sq_trial) : (W+2)'(sq_cat);
    assign sq_root_n = {root[W-2:0], sq_ge};

    // Restoring division of 2^(2F); the only set dividend bit enters on the first step.
    logic [W:0]        dv_cat;
    logic              dv_ge;
    logic [W-1:0]      dv_rem_n;
    logic [QW-1:0]     quo_n;
    logic [QW+W-1:0]   qx;
    logic              q_big;
    assign dv_cat   = {rem_d, cnt == '0};
    assign dv_ge    = dv_cat >= {1'b0, kappa_r};
    assign dv_rem_n = dv_ge ? W'(dv_cat - {1'b0, kappa_r}) : W'(dv_cat);
    assign quo_n    = {quo[QW-2:0], dv_ge};
    assign qx       = {{W{1'b0}}, quo_n};
    assign q_big    = |(qx >> (W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept)                  state_n = DISC;
            DISC:                                 state_n = SQRT;
            SQRT:    if (cnt == CW'(W - 1))       state_n = RECIP;
            RECIP:   if (cnt == CW'(2 * F))       state_n = OUT;
            OUT:     if (deliver)                 state_n = IDLE;
            default:                              state_n = IDLE;
        endcase
        if (!bus.ena) state_n = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            ch_r      <= '0;
            a0_r      <= '0;
            a1_r      <= '0;
            rad       <= '0;
            rem_s     <= '0;
            root      <= '0;
            rem_d     <= '0;
            quo       <= '0;
            kappa_r   <= '0;
            inv_r     <= '0;
            nbh_r     <= '0;
            regime_r  <= '0;
            invalid_r <= 1'b0;
            chg_r     <= 1'b0;
            for (int i = 0; i < NCH; i++) tbl[i] <= '0;
        end else if (bus.ena) begin
            unique case (state)
                IDLE: if (accept) begin
                    a0_r <= bus.a0;
                    a1_r <= bus.a1;
                    ch_r <= CHW'(bus.in_ch % NCH);
                end
                DISC: begin
                    rad      <= rad_in;
                    rem_s    <= '0;
                    root     <= '0;
                    cnt      <= '0;
                    regime_r <= disc[D-1] ? 3'b001 : (disc == '0) ? 3'b010 : 3'b100;
                    nbh_r    <= (a1_r == SMIN) ? SMAX : W'(-$signed(a1_r) >>> 1);
                    if (a1_r != SMIN) nbh_r <= W'(-($signed(a1_r) >>> 1));
                end
                SQRT: begin
                    rad   <= {rad[2*W-3:0], 2'b00};
                    rem_s <= sq_rem_n;
                    root  <= sq_root_n;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        cnt     <= '0;
                        rem_d   <= '0;
                        quo     <= '0;
                        kappa_r <= {1'b0, sq_root_n[W-1:1]};
                    end
                end
                RECIP: begin
                    rem_d <= dv_rem_n;
                    quo   <= quo_n;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(2 * F)) begin
                        cnt       <= '0;
                        invalid_r <= (kappa_r == '0);
                        inv_r     <= (q_big || kappa_r == '0) ? SMAX : W'(quo_n);
                        chg_r     <= (regime_r != tbl[ch_r]);
                        tbl[ch_r] <= regime_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid     = (state == OUT);
    assign bus.busy          = (state != IDLE);
    assign bus.out_ch        = ch_r;
    assign bus.regime        = regime_r;
    assign bus.kappa         = kappa_r;
    assign bus.inv_kappa     = inv_r;
    assign bus.neg_beta_half = nbh_r;
    assign bus.invalid       = invalid_r;
    assign bus.regime_chg    = chg_r;
endmodule
